// File: rtl/bias_seq_pkg.sv
// Shared FSM state type, default lane width and saturating adder for the bias stage.
package bias_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_DW = 18;

    localparam logic signed [DEF_DW-1:0] SAT_MAX = {1'b0, {(DEF_DW-1){1'b1}}};
    localparam logic signed [DEF_DW-1:0] SAT_MIN = {1'b1, {(DEF_DW-1){1'b0}}};

    function automatic logic signed [DEF_DW-1:0] sat_add(
        input logic signed [DEF_DW-1:0] a,
        input logic signed [DEF_DW-1:0] b
    );
        logic signed [DEF_DW:0] s;
        s = {a[DEF_DW-1], a} + {b[DEF_DW-1], b};
        // Overflow iff the extra sign bit disagrees with the lane sign bit.
        if (s[DEF_DW] != s[DEF_DW-1]) begin
            sat_add = s[DEF_DW] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = s[DEF_DW-1:0];
        end
    endfunction

endpackage

// File: rtl/bias_sat_add.sv
// One lane: signed acc + bias with saturation; BIAS_SEQ_RELU_EN additionally clamps negatives to 0.
module bias_sat_add
    import bias_seq_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] bias,
    output logic [DW-1:0] res
);

    logic [DW-1:0] sat;

    generate
        if (DW == DEF_DW) begin : g_pkg
            assign sat = sat_add(acc, bias);
        end else begin : g_gen
            logic [DW:0] sum;
            assign sum = {acc[DW-1], acc} + {bias[DW-1], bias};
            always_comb begin
                sat = sum[DW-1:0];
                if (sum[DW] != sum[DW-1]) begin
                    sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
                end
            end
        end
    endgenerate

`ifdef BIAS_SEQ_RELU_EN
    assign res = sat[DW-1] ? '0 : sat;
`else
    assign res = sat;
`endif

endmodule

// File: rtl/bias_seq_ctrl.sv
// Bias-stage sequencer: group/pixel counters, bias bank select, per-lane saturating add, output register.
// Optional fused ReLU via BIAS_SEQ_RELU_EN (in bias_sat_add).
module bias_seq_ctrl
    import bias_seq_pkg::*;
#(
    parameter  int N_adder_tree = 16,
    parameter  int DW           = DEF_DW,
    parameter  int N_GROUPS     = 4,
    parameter  int N_PIX        = 196,
    localparam int GW           = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    localparam int PW           = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic [N_adder_tree*DW-1:0] acc_data,
    output logic [GW-1:0]              bias_grp,
    input  logic [N_adder_tree*DW-1:0] bias_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_adder_tree*DW-1:0] out_data,
    output logic                       busy,
    output logic                       done
);

    state_t                     state;
    logic [PW-1:0]              pix_cnt;
    logic [GW-1:0]              grp_cnt;
    logic [N_adder_tree*DW-1:0] sum_data;
    logic                       accept;
    logic                       last_pix;
    logic                       last_grp;

    // Combinational on out_ready so a stalled output blocks the next beat in the same cycle.
    assign acc_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept    = acc_valid && acc_ready;
    assign last_pix  = (pix_cnt == PW'(N_PIX - 1));
    assign last_grp  = (grp_cnt == GW'(N_GROUPS - 1));
    assign bias_grp  = grp_cnt;

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        bias_sat_add #(
            .DW(DW)
        ) u_lane (
            .acc (acc_data[DW*i +: DW]),
            .bias(bias_data[DW*i +: DW]),
            .res (sum_data[DW*i +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            grp_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sum_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        pix_cnt <= '0;
                        grp_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_pix) begin
                            pix_cnt <= '0;
                            if (last_grp) begin
                                grp_cnt <= '0;
                                state   <= DRAIN;
                            end else begin
                                grp_cnt <= grp_cnt + 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Scoreboard bench for bias_seq_ctrl: driver pushes model results, monitor pops on output handshakes.
module tb_bias_seq_ctrl;

    localparam int LANES    = 4;
    localparam int DW       = 18;
    localparam int N_GROUPS = 2;
    localparam int N_PIX    = 3;
    localparam int TOTAL    = N_GROUPS * N_PIX;
    localparam int VW       = LANES * DW;
    localparam int SMAX     = 131071;
    localparam int SMIN     = -131072;

    typedef logic [VW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          acc_valid;
    logic          acc_ready;
    vec_t          acc_data;
    logic [0:0]    bias_grp;
    vec_t          bias_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    vec_t          out_data;
    logic          busy;
    logic          done;

    int   bank [N_GROUPS][LANES];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   done_seen = 0;
    int   rdy_mode = 0;
    int   stall_at = 1000000;
    int   dmode = 0;

    bias_seq_ctrl #(
        .N_adder_tree(LANES),
        .DW          (DW),
        .N_GROUPS    (N_GROUPS),
        .N_PIX       (N_PIX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .acc_valid(acc_valid),
        .acc_ready(acc_ready),
        .acc_data (acc_data),
        .bias_grp (bias_grp),
        .bias_data(bias_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External bias bank mux driven from the DUT's select.
    always_comb begin
        bias_data = '0;
        for (int i = 0; i < LANES; i++) bias_data[DW*i +: DW] = DW'(bank[bias_grp][i]);
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(99) < 70);
            default: out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
        endcase
    end

    task automatic check(input bit ok, input string name, input vec_t act, input vec_t req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int rnd_val();
        if ($urandom_range(1) == 0) return int'($urandom_range(2000)) - 1000;
        return int'($urandom_range(262143)) - 131072;
    endfunction

    // Expected lanes: clamp(acc + bias of group g) to the signed DW range.
    function automatic vec_t model(input vec_t a, input int g);
        vec_t r;
        int   s;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            s = int'($signed(a[DW*i +: DW])) + bank[g][i];
            if (s > SMAX) s = SMAX;
            if (s < SMIN) s = SMIN;
`ifdef BIAS_SEQ_RELU_EN
            if (s < 0) s = 0;
`endif
            r[DW*i +: DW] = DW'(s);
        end
        return r;
    endfunction

    function automatic vec_t gen(input int idx);
        vec_t v;
        int   x;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            case (dmode)
                0:       x = 100;
                1:       x = (idx < N_PIX) ? 131000 : -131000;
                default: x = rnd_val();
            endcase
            v[DW*i +: DW] = DW'(x);
        end
        return v;
    endfunction

    // Monitor: compare on every output handshake; check hold and backpressure while stalled.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_out", out_data, '0);
                end else if (out_ready) begin
                    vec_t e;
                    e = exp_q.pop_front();
                    check(out_data === e, "out_data", out_data, e);
                end else begin
                    check(out_data === exp_q[0], "out_hold", out_data, exp_q[0]);
                    check(acc_ready === 1'b0, "bp_acc_ready", vec_t'(acc_ready), '0);
                end
            end
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check(acc_ready === 1'b0, {tag, "_acc_ready"}, vec_t'(acc_ready), '0);
        check(out_valid === 1'b0, {tag, "_out_valid"}, vec_t'(out_valid), '0);
        check(out_data === '0, {tag, "_out_data"}, out_data, '0);
        check(bias_grp === 1'b0, {tag, "_bias_grp"}, vec_t'(bias_grp), '0);
        check(busy === 1'b0, {tag, "_busy"}, vec_t'(busy), '0);
        check(done === 1'b0, {tag, "_done"}, vec_t'(done), '0);
    endtask

    task automatic run_pass(input int vpct, input int start_at, input int abort_at, input bit chk_lat);
        int sent;
        int budget;
        int extra;
        int dcyc;
        int d0;
        bit got;
        sent = 0;
        budget = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check(busy === 1'b1, "busy_after_start", vec_t'(busy), vec_t'(1));
        while (sent < TOTAL && budget < 2000) begin
            acc_valid = ($urandom_range(99) < vpct);
            acc_data  = gen(sent);
            start     = (start_at >= 0 && sent == start_at);
            @(negedge clk);
            if (abort_at >= 0 && sent == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_vals("abort");
                exp_q.delete();
                d0 = done_seen;
                acc_valid = 1'b0;
                start = 1'b0;
                @(negedge clk); #2 rst_n = 1'b1;
                repeat (5) @(posedge clk);
                #1 check(done_seen == d0, "abort_no_done", vec_t'(done_seen), vec_t'(d0));
                return;
            end
            if (acc_valid && acc_ready) begin
                exp_q.push_back(model(acc_data, sent / N_PIX));
                check(bias_grp === 1'((sent / N_PIX)), "bias_grp", vec_t'(bias_grp), vec_t'(sent / N_PIX));
                sent++;
                last_acc = cyc;
            end
            @(posedge clk); #1;
            budget++;
        end
        check(sent == TOTAL, "pass_beats", vec_t'(sent), vec_t'(TOTAL));
        // Keep offering beats; none may be taken once the pass is complete.
        acc_valid = 1'b1;
        start = 1'b0;
        got = 1'b0;
        extra = 0;
        dcyc = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (acc_ready === 1'b1) extra++;
            if (done === 1'b1) begin
                got = 1'b1;
                dcyc = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        check(got, "done_seen", vec_t'(got), vec_t'(1));
        check(extra == 0, "extra_beats", vec_t'(extra), '0);
        check(exp_q.size() == 0, "queue_empty", vec_t'(exp_q.size()), '0);
        if (chk_lat) check(dcyc - last_acc == 2, "done_latency", vec_t'(dcyc - last_acc), vec_t'(2));
        @(posedge clk); #1;
        @(negedge clk);
        check(busy === 1'b0, "busy_fall", vec_t'(busy), '0);
        check(done === 1'b0, "done_pulse", vec_t'(done), '0);
        acc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        acc_valid = 1'b0;
        acc_data = '0;
        for (int g = 0; g < N_GROUPS; g++)
            for (int i = 0; i < LANES; i++) bank[g][i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);
        check(acc_ready === 1'b0, "idle_acc_ready", vec_t'(acc_ready), '0);

        // Nominal: -392 / +20 banks, acc lanes 100.
        for (int i = 0; i < LANES; i++) begin
            bank[0][i] = -392;
            bank[1][i] = 20;
        end
        dmode = 0;
        rdy_mode = 0;
        run_pass(100, -1, -1, 1'b1);

        // Saturation at both rails.
        for (int i = 0; i < LANES; i++) begin
            bank[0][i] = 1000;
            bank[1][i] = -1000;
        end
        dmode = 1;
        run_pass(100, -1, -1, 1'b1);

        // Random banks from here on.
        for (int g = 0; g < N_GROUPS; g++)
            for (int i = 0; i < LANES; i++) bank[g][i] = rnd_val();
        dmode = 2;

        // Five-cycle backpressure inside the first group.
        stall_at = cyc + 4;
        rdy_mode = 2;
        run_pass(100, -1, -1, 1'b0);
        rdy_mode = 0;
        stall_at = 1000000;

        // start pulse while running is ignored.
        run_pass(100, 2, -1, 1'b1);

        // Reset on the fourth beat, then a fresh full pass from group 0.
        run_pass(100, -1, 3, 1'b0);
        run_pass(100, -1, -1, 1'b1);

        // Random bubbles and random output backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 4; p++) begin
            for (int g = 0; g < N_GROUPS; g++)
                for (int i = 0; i < LANES; i++) bank[g][i] = rnd_val();
            run_pass(50, -1, -1, 1'b0);
        end
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
